// File: rtl/pv_interneuron_bank_pkg.sv
// Shared definitions for the PV interneuron bank: default gains and FSM encoding.
package pv_interneuron_bank_pkg;

    // Q4.14 defaults: alpha = 0.05, pyramid->PV = 0.5, PV->pyramid = 0.3
    localparam int DEF_TAU_INV  = 819;
    localparam int DEF_K_EXCITE = 8192;
    localparam int DEF_K_INHIB  = 4915;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        S_SCALE = 2'd1,
        S_DELTA = 2'd2,
        S_INHIB = 2'd3
    } pv_state_t;

endpackage

// File: rtl/pv_interneuron_bank_mul_sat.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by FRAC, clamp to WIDTH.
module pv_mul_sat #(
    parameter int WIDTH = 18,
    parameter int FRAC  = 14
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y,
    output logic                    ovf
);
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shifted;
    logic        [WIDTH:0]     hi_bits;

    assign a_ext   = $signed({{WIDTH{a[WIDTH-1]}}, a});
    assign b_ext   = $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod    = a_ext * b_ext;
    assign shifted = prod >>> FRAC;

    // Result fits only if every bit above the WIDTH-bit sign matches the sign
    assign hi_bits = shifted[2*WIDTH-1:WIDTH-1];
    assign ovf     = !((&hi_bits) || !(|hi_bits));

    always_comb begin
        y = shifted[WIDTH-1:0];
        if (ovf) begin
            y = shifted[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/pv_interneuron_bank.sv
// N_CH-channel PV basket-cell leaky integrator bank; one time-multiplexed multiplier,
// three multiply states per channel, one sweep per clk_en.
module pv_interneuron_bank
    import pv_interneuron_bank_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 18,
    parameter int FRAC  = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] tau_inv,
    input  logic signed [WIDTH-1:0] k_excite,
    input  logic signed [WIDTH-1:0] k_inhib,
    input  logic [N_CH*WIDTH-1:0]   pyramid_in,
    output logic [N_CH*WIDTH-1:0]   inhibition,
    output logic [N_CH*WIDTH-1:0]   pv_state_out,
    output logic                    busy,
    output logic                    done,
    output logic                    sat_flag,
    output logic                    overrun_flag
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    pv_state_t state_reg, state_next;
    logic [CH_W-1:0]         ch_reg;
    logic signed [WIDTH-1:0] x_sh_reg [N_CH];
    logic signed [WIDTH-1:0] pv_reg   [N_CH];
    logic signed [WIDTH-1:0] inh_reg  [N_CH];
    logic signed [WIDTH-1:0] tau_reg, ke_reg, ki_reg, sc_reg;
    logic                    done_reg, sat_reg, overrun_reg;

    logic signed [WIDTH-1:0] mul_a, mul_b, mul_y;
    logic                    mul_ovf;
    logic signed [WIDTH-1:0] pv_cur, diff_sat, sum_sat;
    logic signed [WIDTH:0]   diff_wide, sum_wide;
    logic                    diff_ovf, sum_ovf, clamp_hit;

    function automatic logic signed [WIDTH-1:0] sat_narrow(input logic signed [WIDTH:0] v);
        if (v[WIDTH] != v[WIDTH-1])
            return v[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return v[WIDTH-1:0];
    endfunction

    assign pv_cur    = pv_reg[ch_reg];
    assign diff_wide = {sc_reg[WIDTH-1], sc_reg} - {pv_cur[WIDTH-1], pv_cur};
    assign diff_ovf  = diff_wide[WIDTH] ^ diff_wide[WIDTH-1];
    assign diff_sat  = sat_narrow(diff_wide);
    assign sum_wide  = {pv_cur[WIDTH-1], pv_cur} + {mul_y[WIDTH-1], mul_y};
    assign sum_ovf   = sum_wide[WIDTH] ^ sum_wide[WIDTH-1];
    assign sum_sat   = sat_narrow(sum_wide);

    pv_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
        .a   (mul_a),
        .b   (mul_b),
        .y   (mul_y),
        .ovf (mul_ovf)
    );

    always_comb begin
        state_next = state_reg;
        mul_a      = '0;
        mul_b      = '0;
        clamp_hit  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clk_en) state_next = S_SCALE;
            end
            S_SCALE: begin
                mul_a      = x_sh_reg[ch_reg];
                mul_b      = ke_reg;
                clamp_hit  = mul_ovf;
                state_next = S_DELTA;
            end
            S_DELTA: begin
                mul_a      = diff_sat;
                mul_b      = tau_reg;
                clamp_hit  = diff_ovf | mul_ovf | sum_ovf;
                state_next = S_INHIB;
            end
            S_INHIB: begin
                // pv_reg[ch] already holds the value written in S_DELTA
                mul_a      = pv_cur;
                mul_b      = ki_reg;
                clamp_hit  = mul_ovf;
                state_next = (ch_reg == LAST_CH) ? IDLE : S_SCALE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_reg      <= '0;
            tau_reg     <= '0;
            ke_reg      <= '0;
            ki_reg      <= '0;
            sc_reg      <= '0;
            done_reg    <= 1'b0;
            sat_reg     <= 1'b0;
            overrun_reg <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                x_sh_reg[i] <= '0;
                pv_reg[i]   <= '0;
                inh_reg[i]  <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            if (clk_en && state_reg != IDLE) overrun_reg <= 1'b1;
            if (clamp_hit) sat_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (clk_en) begin
                        ch_reg  <= '0;
                        tau_reg <= tau_inv;
                        ke_reg  <= k_excite;
                        ki_reg  <= k_inhib;
                        for (int i = 0; i < N_CH; i++)
                            x_sh_reg[i] <= pyramid_in[i*WIDTH +: WIDTH];
                    end
                end
                S_SCALE: sc_reg <= mul_y;
                S_DELTA: pv_reg[ch_reg] <= sum_sat;
                S_INHIB: begin
                    inh_reg[ch_reg] <= mul_y;
                    if (ch_reg == LAST_CH) done_reg <= 1'b1;
                    else                   ch_reg   <= ch_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_out
            assign inhibition[gi*WIDTH +: WIDTH]   = inh_reg[gi];
            assign pv_state_out[gi*WIDTH +: WIDTH] = pv_reg[gi];
        end
    endgenerate

    assign busy         = (state_reg != IDLE);
    assign done         = done_reg;
    assign sat_flag     = sat_reg;
    assign overrun_flag = overrun_reg;

endmodule

// File: tb/tb_pv_interneuron_bank.sv
// Scoreboard bench for pv_interneuron_bank: a behavioural model pushes expected
// per-channel state at each accepted clk_en; the done monitor pops and compares.
module tb_pv_interneuron_bank;
    import pv_interneuron_bank_pkg::*;

    localparam int N = 4;
    localparam int W = 18;
    localparam int F = 14;

    typedef longint vec_t [N];

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                clk_en = 1'b0;
    logic signed [W-1:0] tau_inv = '0;
    logic signed [W-1:0] k_excite = '0;
    logic signed [W-1:0] k_inhib = '0;
    logic [N*W-1:0]      pyramid_in = '0;
    logic [N*W-1:0]      inhibition;
    logic [N*W-1:0]      pv_state_out;
    logic                busy, done, sat_flag, overrun_flag;

    always #5 clk = ~clk;

    pv_interneuron_bank #(.N_CH(N), .WIDTH(W), .FRAC(F)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_en       (clk_en),
        .tau_inv      (tau_inv),
        .k_excite     (k_excite),
        .k_inhib      (k_inhib),
        .pyramid_in   (pyramid_in),
        .inhibition   (inhibition),
        .pv_state_out (pv_state_out),
        .busy         (busy),
        .done         (done),
        .sat_flag     (sat_flag),
        .overrun_flag (overrun_flag)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        chk_cnt++;
        if (obs == exp) pass_cnt++;
        else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    longint m_pv [N];
    bit     m_sat = 1'b0;

    function automatic longint sat_m(input longint v);
        if (v > 131071)  begin m_sat = 1'b1; return 131071;  end
        if (v < -131072) begin m_sat = 1'b1; return -131072; end
        return v;
    endfunction

    function automatic longint mul_m(input longint a, input longint b);
        return sat_m((a * b) >>> F);
    endfunction

    function automatic longint ch_val(input logic [N*W-1:0] v, input int c);
        logic signed [W-1:0] t;
        t = v[c*W +: W];
        return longint'(t);
    endfunction

    logic [N*W-1:0] q_pv  [$];
    logic [N*W-1:0] q_inh [$];
    bit             q_sat [$];

    task automatic begin_sweep(input vec_t x, input longint tau, input longint ke, input longint ki);
        logic [N*W-1:0] e_pv, e_inh;
        longint sc, d;
        for (int c = 0; c < N; c++) pyramid_in[c*W +: W] = W'(x[c]);
        tau_inv  = W'(tau);
        k_excite = W'(ke);
        k_inhib  = W'(ki);
        clk_en   = 1'b1;
        for (int c = 0; c < N; c++) begin
            sc       = mul_m(x[c], ke);
            d        = mul_m(sat_m(sc - m_pv[c]), tau);
            m_pv[c]  = sat_m(m_pv[c] + d);
            e_pv[c*W +: W]  = W'(m_pv[c]);
            e_inh[c*W +: W] = W'(mul_m(m_pv[c], ki));
        end
        q_pv.push_back(e_pv);
        q_inh.push_back(e_inh);
        q_sat.push_back(m_sat);
        @(negedge clk);
        clk_en = 1'b0;
        // Scramble inputs: the sweep must run from its shadow copies
        pyramid_in = {$urandom, $urandom, $urandom};
        tau_inv    = W'($urandom);
        k_excite   = W'($urandom);
        k_inhib    = W'($urandom);
    endtask

    task automatic wait_done(input int lat0, input int busy0);
        int lat = lat0;
        int bc  = busy0;
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1'b1;
            else if (busy) bc++;
        end
        if (!seen) check("done_timeout", 0, 1);
        else begin
            check("latency", lat, 13);
            check("busy_cycles", bc, 12);
        end
    endtask

    int sweep_no = 0;
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q_pv.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                logic [N*W-1:0] e_pv, e_inh;
                bit e_sat;
                e_pv  = q_pv.pop_front();
                e_inh = q_inh.pop_front();
                e_sat = q_sat.pop_front();
                for (int c = 0; c < N; c++) begin
                    check($sformatf("pv%0d", c),  ch_val(pv_state_out, c), ch_val(e_pv, c));
                    check($sformatf("inh%0d", c), ch_val(inhibition, c),   ch_val(e_inh, c));
                end
                check("sat_flag", longint'(sat_flag), longint'(e_sat));
                $display("sweep %0d: pv=%0d,%0d,%0d,%0d inh=%0d,%0d,%0d,%0d sat=%0b ovr=%0b",
                         sweep_no, ch_val(pv_state_out, 0), ch_val(pv_state_out, 1),
                         ch_val(pv_state_out, 2), ch_val(pv_state_out, 3),
                         ch_val(inhibition, 0), ch_val(inhibition, 1),
                         ch_val(inhibition, 2), ch_val(inhibition, 3), sat_flag, overrun_flag);
            end
            sweep_no++;
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_inh"},  longint'(inhibition), 0);
        check({tag, "_pv"},   longint'(pv_state_out), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_sat"},  longint'(sat_flag), 0);
        check({tag, "_ovr"},  longint'(overrun_flag), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint prev, cur;
        bit mono_ok;
        for (int c = 0; c < N; c++) m_pv[c] = 0;

        // Power-on reset
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single unit input on ch0
        begin_sweep('{16384, 0, 0, 0}, DEF_TAU_INV, DEF_K_EXCITE, DEF_K_INHIB);
        wait_done(1, 1);
        check("t2_pv0",  ch_val(pv_state_out, 0), 409);
        check("t2_inh0", ch_val(inhibition, 0),   122);
        check("t2_pv1",  ch_val(pv_state_out, 1), 0);

        // Negative input on ch2: floor rounding
        begin_sweep('{0, 0, -16384, 0}, DEF_TAU_INV, DEF_K_EXCITE, DEF_K_INHIB);
        wait_done(1, 1);
        check("t3_pv2",  ch_val(pv_state_out, 2), -410);
        check("t3_inh2", ch_val(inhibition, 2),   -123);

        // Reset mid-sweep at cycle 5
        begin_sweep('{5000, -3000, 7000, 100}, DEF_TAU_INV, DEF_K_EXCITE, DEF_K_INHIB);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_cleared("midrst");
        q_pv.delete();
        q_inh.delete();
        q_sat.delete();
        for (int c = 0; c < N; c++) m_pv[c] = 0;
        m_sat = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_no_done", longint'(done), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_cleared("post_rst");

        // Held input: convergence; each next clk_en lands on the done cycle
        prev    = 0;
        mono_ok = 1'b1;
        for (int s = 0; s < 400; s++) begin
            begin_sweep('{16384, 0, 0, 0}, DEF_TAU_INV, DEF_K_EXCITE, DEF_K_INHIB);
            wait_done(1, 1);
            cur = ch_val(pv_state_out, 0);
            if (cur < prev) mono_ok = 1'b0;
            prev = cur;
        end
        check("t4_monotonic", longint'(mono_ok), 1);
        check("t4_settled",   longint'(prev >= 8172 && prev <= 8192), 1);
        check("t4_sat",       longint'(sat_flag), 0);
        check("t4_no_overrun_on_done_cycle", longint'(overrun_flag), 0);

        // clk_en pulsed mid-sweep: ignored, flagged
        begin_sweep('{-20000, 30000, 1234, -5}, DEF_TAU_INV, DEF_K_EXCITE, DEF_K_INHIB);
        repeat (2) @(negedge clk);
        clk_en = 1'b1;
        @(negedge clk);
        clk_en = 1'b0;
        wait_done(4, 4);
        check("t6_overrun", longint'(overrun_flag), 1);
        begin_sweep('{100, 200, 300, 400}, DEF_TAU_INV, DEF_K_EXCITE, DEF_K_INHIB);
        wait_done(1, 1);

        // Saturating scale stage
        begin_sweep('{131071, 131071, 131071, 131071}, DEF_TAU_INV, 131071, DEF_K_INHIB);
        wait_done(1, 1);
        check("t5_sat", longint'(sat_flag), 1);
        for (int c = 0; c < N; c++)
            check($sformatf("t5_pos%0d", c), longint'(ch_val(pv_state_out, c) > 0), 1);

        repeat (3) @(negedge clk);
        check("queue_drained", q_pv.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
